// File: rtl/umsg_scheduler.sv
// UMsg scheduler: per-slot hint/data delay FSMs feeding a round-robin arbiter
// and a single registered output stage toward the AFU receive path.

`ifndef UMSG_DELAY_TIMER_LOG2
`define UMSG_DELAY_TIMER_LOG2 4
`endif

module umsg_scheduler #(
  parameter int NUM_UMSG   = 8,
  parameter int TIMER_W    = `UMSG_DELAY_TIMER_LOG2,
  parameter int HINT_DELAY = 4,
  parameter int DATA_DELAY = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_UMSG-1:0]      hint_en,
  input  logic                     cmd_valid,
  input  logic [5:0]               cmd_id,
  input  logic [511:0]             cmd_data,
  output logic                     cmd_ready,
  output logic [NUM_UMSG-1:0]      slot_idle,
  output logic                     umsg_valid,
  output logic [27:0]              umsg_hdr,
  output logic [511:0]             umsg_data,
  input  logic                     umsg_ready,
  output logic [NUM_UMSG-1:0][2:0] dbg_state
);

  // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
  // an output message transfers on a cycle where umsg_valid && umsg_ready, and
  // the output holds header and payload unchanged while valid && !ready.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HINT_WAIT = 3'd1,
    S_SEND_HINT = 3'd2,
    S_DATA_WAIT = 3'd3,
    S_SEND_DATA = 3'd4
  } slot_state_t;

  localparam logic [TIMER_W-1:0] HINT_LOAD = TIMER_W'(HINT_DELAY);
  localparam logic [TIMER_W-1:0] DATA_LOAD = TIMER_W'(DATA_DELAY);

  slot_state_t        state      [NUM_UMSG];
  logic [TIMER_W-1:0] hint_timer [NUM_UMSG];
  logic [TIMER_W-1:0] data_timer [NUM_UMSG];
  logic [511:0]       data_reg   [NUM_UMSG];
  logic [5:0]         rr_ptr;

  logic                accept;
  logic                load_ok;
  logic [NUM_UMSG-1:0] req;
  logic [NUM_UMSG-1:0] req_rot;
  logic                grant_valid;
  logic [5:0]          grant_id;
  logic                grant_is_hint;
  logic [511:0]        grant_data;

  always_comb begin
    cmd_ready = 1'b0;
    slot_idle = '0;
    req       = '0;
    dbg_state = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      slot_idle[i] = (state[i] == S_IDLE);
      req[i]       = (state[i] == S_SEND_HINT) || (state[i] == S_SEND_DATA);
      dbg_state[i] = state[i];
      if (cmd_id == 6'(i))
        cmd_ready = (state[i] == S_IDLE);
    end
  end

  assign accept  = cmd_valid && cmd_ready;
  assign load_ok = !umsg_valid || umsg_ready;

  // Rotate requests so bit 0 is the slot at rr_ptr, then take the first set bit.
  always_comb begin
    req_rot     = NUM_UMSG'({req, req} >> rr_ptr);
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      if (!grant_valid && req_rot[i] && load_ok) begin
        grant_valid = 1'b1;
        if (({1'b0, rr_ptr} + 7'(i)) >= 7'(NUM_UMSG))
          grant_id = rr_ptr + 6'(i) - 6'(NUM_UMSG);
        else
          grant_id = rr_ptr + 6'(i);
      end
    end
  end

  always_comb begin
    grant_is_hint = 1'b0;
    grant_data    = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      if (grant_id == 6'(i)) begin
        grant_is_hint = (state[i] == S_SEND_HINT);
        grant_data    = data_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state[i]      <= S_IDLE;
        hint_timer[i] <= '0;
        data_timer[i] <= '0;
        data_reg[i]   <= '0;
      end
      rr_ptr     <= '0;
      umsg_valid <= 1'b0;
      umsg_hdr   <= '0;
      umsg_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        case (state[i])
          S_IDLE: begin
            if (accept && cmd_id == 6'(i)) begin
              data_reg[i] <= cmd_data;
              if (hint_en[i]) begin
                state[i]      <= S_HINT_WAIT;
                hint_timer[i] <= HINT_LOAD;
              end else begin
                state[i]      <= S_DATA_WAIT;
                data_timer[i] <= DATA_LOAD;
              end
            end
          end
          S_HINT_WAIT: begin
            if (hint_timer[i] == '0)
              state[i] <= S_SEND_HINT;
            else
              hint_timer[i] <= hint_timer[i] - 1'b1;
          end
          S_SEND_HINT: begin
            if (grant_valid && grant_id == 6'(i)) begin
              state[i]      <= S_DATA_WAIT;
              data_timer[i] <= DATA_LOAD;
            end
          end
          S_DATA_WAIT: begin
            if (data_timer[i] == '0)
              state[i] <= S_SEND_DATA;
            else
              data_timer[i] <= data_timer[i] - 1'b1;
          end
          S_SEND_DATA: begin
            if (grant_valid && grant_id == 6'(i))
              state[i] <= S_IDLE;
          end
          default: state[i] <= S_IDLE;
        endcase
      end

      if (grant_valid) begin
        umsg_valid <= 1'b1;
        umsg_hdr   <= {8'h00, 4'h6, grant_is_hint, 9'h000, grant_id};
        umsg_data  <= grant_is_hint ? '0 : grant_data;
        rr_ptr     <= (grant_id == 6'(NUM_UMSG - 1)) ? 6'd0 : grant_id + 6'd1;
      end else if (umsg_ready) begin
        umsg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/umsg_scheduler.md
# umsg_scheduler

Sequences user messages (UMsgs) from the emulator's per-AFU UMsg slots onto the AFU-bound receive path. Each slot runs a hint/data state machine with programmable delay timers. A round-robin arbiter serialises ready hints and data lines into a single registered output stage. The block sits between the software-driven UMsg command interface and the Rx channel mux.

## Interface
Parameters:
- NUM_UMSG, 8: number of UMsg slots (slot id fits in 6 bits, so NUM_UMSG ≤ 64).
- TIMER_W, `UMSG_DELAY_TIMER_LOG2: width of the hint and data delay timers.
- HINT_DELAY, 4: hint timer load value (< 2^TIMER_W).
- DATA_DELAY, 8: data timer load value (< 2^TIMER_W).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- hint_en  in  NUM_UMSG  per-slot hint enable; treated as static while the slot is non-idle.
- cmd_valid  in  1  UMsg command valid.
- cmd_id  in  6  target slot.
- cmd_data  in  512  UMsg payload.
- cmd_ready  out  1  high when slot cmd_id is Idle.
- slot_idle  out  NUM_UMSG  per-slot Idle status.
- umsg_valid  out  1  output message valid.
- umsg_hdr  out  28  UMsg header: [27:26]=0, [25] poison=0, [24:20]=0, [19:16]=4'h6, [15]=umsg_type (1 hint, 0 data), [14:6]=0, [5:0]=slot id.
- umsg_data  out  512  payload; all zeros for a hint.
- umsg_ready  in  1  sink accepts the output this cycle.

## Operation
- A command is accepted when cmd_valid is high, cmd_id < NUM_UMSG, and the slot is Idle.
  - On acceptance, cmd_data is latched into the slot data register.
  - cmd_id ≥ NUM_UMSG: cmd_ready=0 and the command is never accepted.
- Per-slot states are Idle, HintWait, SendHint, DataWait and SendData.
  - Idle → HintWait on accept when hint_en[id]=1; the hint timer loads HINT_DELAY.
  - Idle → DataWait on accept when hint_en[id]=0; the data timer loads DATA_DELAY.
  - HintWait: if timer == 0, go to SendHint; otherwise decrement.
  - SendHint → DataWait on grant; the data timer loads DATA_DELAY.
  - DataWait: if timer == 0, go to SendData; otherwise decrement.
  - SendData → Idle on grant.
- Arbiter:
  - Requesters are slots in SendHint or SendData; hints and data have equal priority.
  - Round-robin: search starts at rr_ptr, and after a grant to slot k, rr_ptr = (k+1) mod NUM_UMSG.
  - A grant is issued only when the output stage can load, i.e. !umsg_valid || umsg_ready.
  - At most one grant per cycle.
- Output stage:
  - 1-deep register, loaded on grant with the header and payload.
  - umsg_valid clears on umsg_ready when there is no new grant.
  - Contents hold stable while umsg_valid && !umsg_ready.
- Timers are TIMER_W bits and never wrap; they stop at 0.

## Timing
- Reset values:
  - All slots Idle; timers 0; rr_ptr=0.
  - umsg_valid=0, umsg_hdr=0, umsg_data=0.
  - slot_idle all ones; cmd_ready follows cmd_id (1 for a legal id).
- Accept at cycle 0 with hint enabled and the output free:
  - HintWait cycles 1..1+HINT_DELAY.
  - SendHint and grant at 2+HINT_DELAY.
  - Hint umsg_valid at 3+HINT_DELAY.
- Hint grant at cycle G, output free:
  - DataWait at G+1..G+1+DATA_DELAY.
  - Grant at G+2+DATA_DELAY.
  - Data umsg_valid at G+3+DATA_DELAY; slot Idle at the same cycle.
- Hint disabled: data umsg_valid at 3+DATA_DELAY after accept.
- Back-to-back: with umsg_ready held high, one message per cycle is sustained.
- Stall: a slot waits in SendHint or SendData indefinitely. Its data register and state are held, and no message is lost or duplicated.
- New command for a slot whose SendData grant happens in cycle t: refused in cycle t, accepted at t+1.
- rst mid-operation: all slots go Idle, pending payloads are discarded, and umsg_valid=0 on the next cycle.

## Test plan
- HINT_DELAY=4, DATA_DELAY=8, hint_en[3]=1, cmd_id=3 data=0xA5 pattern at cycle 0, umsg_ready=1:
  - hint hdr[15]=1, id=3 valid at cycle 7 for one cycle;
  - data hdr[15]=0, id=3, payload 0xA5 pattern at cycle 17;
  - slot_idle[3]=1 at cycle 17.
- hint_en=0, commands to slots 0, 1, 2 on consecutive cycles with DATA_DELAY=0:
  - data messages appear in id order 0, 1, 2 on cycles 3, 4, 5.
- All 8 slots reach SendData in the same cycle:
  - grants go in order 0..7, one per cycle;
  - next round starts at rr_ptr=0; no slot is starved.
- umsg_ready low for 10 cycles with slot 5 pending:
  - umsg_valid, umsg_hdr and umsg_data are stable throughout;
  - exactly one transfer occurs when ready rises.
- Command to a busy slot:
  - cmd_ready=0 and the data is unchanged;
  - cmd_id=40 is never accepted.
- rst asserted during HintWait of slot 2 and again while umsg_valid=1:
  - next cycle all outputs are at reset values;
  - no stale message is emitted afterwards.
